// File: rtl/yari_mem_arbiter_pkg.sv
// Shared definitions for the yari memory arbiter: read-return tags, the
// flattened master request record and the grant encoding.
package yari_mem_arbiter_pkg;

    localparam logic TAG_I = 1'b0;
    localparam logic TAG_D = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic        write;
        logic [31:0] wrdata;
        logic [3:0]  wrmask;
    } mem_req_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_I    = 2'd1,
        GRANT_D    = 2'd2
    } grant_e;

    // A read needs a free tag slot; a request that also reads is held back
    // while the tag FIFO is full so no tag is ever dropped.
    function automatic logic req_eligible(input mem_req_t req, input logic fifo_full);
        return (req.read | req.write) & ~(req.read & fifo_full);
    endfunction

endpackage

// File: rtl/yari_tag_fifo.sv
// 1-bit-wide synchronous FIFO holding the issuing master of each outstanding
// read, in issue order. Head is presented combinationally.
module yari_tag_fifo
    import yari_mem_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH_LOG2 = 2
) (
    input  logic clock,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int DEPTH = 1 << TAG_DEPTH_LOG2;
    localparam logic [TAG_DEPTH_LOG2:0] FULL_COUNT = (TAG_DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH-1:0]          r_mem;
    logic [TAG_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [TAG_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [TAG_DEPTH_LOG2:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Full/empty come from the registered count, so a same-cycle pop never
    // makes room for a push.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/yari_mem_arbiter.sv
// Merges the yari instruction-fetch and data masters onto one memory port and
// routes in-order read returns back to the master that issued each read.
module yari_mem_arbiter
    import yari_mem_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH_LOG2 = 2
) (
    input  logic        clock,
    input  logic        rst,

    input  logic [31:0] i_addr,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_wrdata,
    input  logic [3:0]  i_wrmask,
    output logic        i_hold,
    output logic [31:0] i_rddata,
    output logic        i_rdvalid,

    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_wrdata,
    input  logic [3:0]  d_wrmask,
    output logic        d_hold,
    output logic [31:0] d_rddata,
    output logic        d_rdvalid,

    output logic [31:0] s_addr,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_wrdata,
    output logic [3:0]  s_wrmask,
    input  logic        s_hold,
    input  logic [31:0] s_rddata,
    input  logic        s_rdvalid,

    output logic        tag_underflow
);

    mem_req_t w_i_req;
    mem_req_t w_d_req;
    mem_req_t w_s_req;
    grant_e   w_grant;

    logic w_i_active;
    logic w_d_active;
    logic w_i_elig;
    logic w_d_elig;
    logic w_contest;
    logic w_accept;
    logic w_push;
    logic w_push_tag;
    logic w_pop_ok;
    logic w_head;
    logic w_full;
    logic w_empty;

    logic r_last_contest_lost_i;
    logic r_tag_underflow;

    assign w_i_req = {i_addr, i_read, i_write, i_wrdata, i_wrmask};
    assign w_d_req = {d_addr, d_read, d_write, d_wrdata, d_wrmask};

    assign w_i_active = i_read | i_write;
    assign w_d_active = d_read | d_write;
    assign w_i_elig   = req_eligible(w_i_req, w_full);
    assign w_d_elig   = req_eligible(w_d_req, w_full);
    assign w_contest  = w_i_elig & w_d_elig;

    // d has priority except right after i lost a contest, which bounds the
    // wait of either master to one contested accept.
    always_comb begin
        w_grant = GRANT_NONE;
        if (w_d_elig && (!w_i_elig || !r_last_contest_lost_i)) begin
            w_grant = GRANT_D;
        end else if (w_i_elig) begin
            w_grant = GRANT_I;
        end
    end

    assign w_s_req  = (w_grant == GRANT_I) ? w_i_req : w_d_req;
    assign s_addr   = w_s_req.addr;
    assign s_wrdata = w_s_req.wrdata;
    assign s_wrmask = w_s_req.wrmask;
    assign s_read   = (w_grant != GRANT_NONE) & w_s_req.read;
    assign s_write  = (w_grant != GRANT_NONE) & w_s_req.write;

    assign w_accept = (w_grant != GRANT_NONE) & ~s_hold;
    assign i_hold   = w_i_active & ~((w_grant == GRANT_I) & ~s_hold);
    assign d_hold   = w_d_active & ~((w_grant == GRANT_D) & ~s_hold);

    assign w_push     = w_accept & w_s_req.read;
    assign w_push_tag = (w_grant == GRANT_D) ? TAG_D : TAG_I;

    yari_tag_fifo #(
        .TAG_DEPTH_LOG2(TAG_DEPTH_LOG2)
    ) u_tag_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (w_push),
        .pop   (s_rdvalid),
        .din   (w_push_tag),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Read data is broadcast; only the valid strobe is steered by the tag.
    assign w_pop_ok  = s_rdvalid & ~w_empty;
    assign i_rdvalid = w_pop_ok & (w_head == TAG_I);
    assign d_rdvalid = w_pop_ok & (w_head == TAG_D);
    assign i_rddata  = s_rddata;
    assign d_rddata  = s_rddata;

    assign tag_underflow = r_tag_underflow;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_last_contest_lost_i <= 1'b0;
            r_tag_underflow       <= 1'b0;
        end else begin
            if (w_contest && !s_hold) begin
                r_last_contest_lost_i <= (w_grant == GRANT_D);
            end
            if (s_rdvalid && w_empty) begin
                r_tag_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_yari_mem_arbiter.sv
// Directed bench for yari_mem_arbiter with a read-return scoreboard.
module tb_yari_mem_arbiter;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [31:0] i_addr = '0, d_addr = '0;
    logic        i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [31:0] i_wrdata = '0, d_wrdata = '0;
    logic [3:0]  i_wrmask = '0, d_wrmask = '0;
    logic        i_hold, d_hold, i_rdvalid, d_rdvalid;
    logic [31:0] i_rddata, d_rddata;
    logic [31:0] s_addr, s_wrdata;
    logic        s_read, s_write;
    logic [3:0]  s_wrmask;
    logic        s_hold = 1'b0;
    logic [31:0] s_rddata = '0;
    logic        s_rdvalid = 1'b0;
    logic        tag_underflow;

    int checks = 0;
    int failures = 0;
    int wr_issued = 0;

    logic [32:0] exp_q[$];
    logic [31:0] mem_q[$];

    yari_mem_arbiter #(.TAG_DEPTH_LOG2(2)) dut (
        .clock(clock), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wrdata(i_wrdata),
        .i_wrmask(i_wrmask), .i_hold(i_hold), .i_rddata(i_rddata), .i_rdvalid(i_rdvalid),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wrdata(d_wrdata),
        .d_wrmask(d_wrmask), .d_hold(d_hold), .d_rddata(d_rddata), .d_rdvalid(d_rdvalid),
        .s_addr(s_addr), .s_read(s_read), .s_write(s_write), .s_wrdata(s_wrdata),
        .s_wrmask(s_wrmask), .s_hold(s_hold), .s_rddata(s_rddata), .s_rdvalid(s_rdvalid),
        .tag_underflow(tag_underflow)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    always @(posedge clock) begin
        if (!rst && s_write && !s_hold) wr_issued++;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Drive phase starts 1ns after the edge; checks happen mid-cycle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_masters();
        i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic drive_return();
        if (mem_q.size() > 0) begin
            s_rdvalid = 1'b1;
            s_rddata  = mem_q.pop_front();
        end else begin
            s_rdvalid = 1'b0;
        end
    endtask

    task automatic check_return();
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check_eq("sb_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("rd_valid", {62'd0, i_rdvalid, d_rdvalid}, e[32] ? 64'd1 : 64'd2);
            check_eq("rd_data_i", 64'(i_rddata), 64'(e[31:0]));
            check_eq("rd_data_d", 64'(d_rddata), 64'(e[31:0]));
        end
    endtask

    initial begin
        logic        m_lcli;
        logic        win_d;
        int          i_k;
        int          d_k;
        int          wr_base;
        logic [31:0] a;

        // Reset state
        repeat (2) step();
        settle();
        check_eq("rst_underflow", 64'(tag_underflow), 64'd0);
        check_eq("rst_holds", {62'd0, i_hold, d_hold}, 64'd0);
        check_eq("rst_sreq", {62'd0, s_read, s_write}, 64'd0);
        check_eq("rst_rdvalid", {62'd0, i_rdvalid, d_rdvalid}, 64'd0);
        step();
        rst = 1'b0;

        // Solo read
        step();
        i_addr = 32'hBFC0_0000; i_read = 1'b1;
        settle();
        check_eq("solo_sread", 64'(s_read), 64'd1);
        check_eq("solo_saddr", 64'(s_addr), 64'hBFC0_0000);
        check_eq("solo_ihold", 64'(i_hold), 64'd0);
        exp_q.push_back({1'b0, 32'h3C1D_0000});
        step();
        i_read = 1'b0; s_rdvalid = 1'b1; s_rddata = 32'h3C1D_0000;
        settle();
        check_return();
        step();
        s_rdvalid = 1'b0;

        // Contention: both read every cycle, responder returns one cycle later
        m_lcli = 1'b0; i_k = 0; d_k = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            i_read = 1'b1; i_addr = 32'h1000 + 32'(4 * i_k);
            d_read = 1'b1; d_addr = 32'h2000 + 32'(4 * d_k);
            drive_return();
            settle();
            win_d = ~m_lcli;
            a = win_d ? d_addr : i_addr;
            check_eq("cont_saddr", 64'(s_addr), 64'(a));
            check_eq("cont_holds", {62'd0, i_hold, d_hold}, win_d ? 64'd2 : 64'd1);
            if (s_rdvalid) check_return();
            exp_q.push_back({win_d, mem_data(a)});
            mem_q.push_back(mem_data(a));
            m_lcli = win_d;
            if (win_d) d_k++; else i_k++;
        end
        step();
        idle_masters();
        drive_return();
        settle();
        check_return();
        step();
        s_rdvalid = 1'b0;

        // Backpressure on a d-write
        wr_base = wr_issued;
        step();
        s_hold = 1'b1; d_write = 1'b1;
        d_addr = 32'h8000_0010; d_wrdata = 32'h1234_5678; d_wrmask = 4'hF;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq("bp_dhold", 64'(d_hold), 64'd1);
            check_eq("bp_fields", {s_write, s_addr, s_wrdata[30:0]},
                     {1'b1, 32'h8000_0010, 31'h1234_5678});
            check_eq("bp_mask", 64'(s_wrmask), 64'hF);
            step();
        end
        s_hold = 1'b0;
        settle();
        check_eq("bp_release", {62'd0, d_hold, s_write}, 64'd1);
        step();
        d_write = 1'b0;
        settle();
        check_eq("bp_issue_once", 64'(wr_issued - wr_base), 64'd1);

        // FIFO full: four i-reads with no returns
        for (int k = 0; k < 4; k++) begin
            step();
            i_read = 1'b1; i_addr = 32'h100 + 32'(4 * k);
            settle();
            check_eq("fill_ihold", 64'(i_hold), 64'd0);
            exp_q.push_back({1'b0, mem_data(i_addr)});
            mem_q.push_back(mem_data(i_addr));
        end
        step();
        i_addr = 32'h110; d_write = 1'b1; d_addr = 32'h8000_0020;
        settle();
        check_eq("full_holds", {62'd0, i_hold, d_hold}, 64'd2);
        check_eq("full_sreq", {62'd0, s_read, s_write}, 64'd1);
        step();
        d_write = 1'b0;
        drive_return();
        settle();
        check_eq("full_pop_ihold", 64'(i_hold), 64'd1);
        check_return();
        step();
        s_rdvalid = 1'b0;
        settle();
        check_eq("full_after_ihold", 64'(i_hold), 64'd0);
        check_eq("full_after_sread", {s_read, s_addr}, {1'b1, 32'h110});
        exp_q.push_back({1'b0, mem_data(32'h110)});
        mem_q.push_back(mem_data(32'h110));
        step();
        i_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_return();
            settle();
            check_return();
            step();
        end
        s_rdvalid = 1'b0;

        // Underflow
        step();
        s_rdvalid = 1'b1; s_rddata = 32'hDEAD_BEEF;
        settle();
        check_eq("uf_rdvalid", {62'd0, i_rdvalid, d_rdvalid}, 64'd0);
        check_eq("uf_not_yet", 64'(tag_underflow), 64'd0);
        step();
        s_rdvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq("uf_sticky", 64'(tag_underflow), 64'd1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check_eq("uf_cleared", 64'(tag_underflow), 64'd0);

        // Reset mid-flight with two outstanding reads
        step();
        d_read = 1'b1; d_addr = 32'h300;
        settle();
        check_eq("mf_dread", {62'd0, s_read, d_hold}, 64'd2);
        step();
        d_read = 1'b0; i_read = 1'b1; i_addr = 32'h304;
        settle();
        check_eq("mf_iread", {62'd0, s_read, i_hold}, 64'd2);
        step();
        i_read = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; s_rdvalid = 1'b1; s_rddata = 32'h0000_0300;
        settle();
        check_eq("mf_rdvalid", {62'd0, i_rdvalid, d_rdvalid}, 64'd0);
        step();
        s_rdvalid = 1'b0;
        settle();
        check_eq("mf_underflow", 64'(tag_underflow), 64'd1);

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
